// File: rtl/tetris_line_clear.sv
// tetris_line_clear: removes full rows from a snapshot of the playfield by collapsing the rows above each one,
// then publishes the compacted grid together with saturating score, line and level counters.
module tetris_line_clear #(
    parameter int ROWS            = 22,
    parameter int COLS            = 10,
    parameter int CW              = 3,
    parameter int SCORE_W         = 8,
    parameter int LINES_PER_LEVEL = 10,
    parameter int LW              = $clog2(ROWS + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                clr_score,
    input  logic [ROWS-1:0][COLS-1:0][CW-1:0]   grid_i,
    output logic                                busy,
    output logic                                done,
    output logic [ROWS-1:0][COLS-1:0][CW-1:0]   grid_o,
    output logic [LW-1:0]                       lines_cleared,
    output logic [15:0]                         total_lines,
    output logic [SCORE_W-1:0]                  score,
    output logic [3:0]                          level
);
    localparam int RBW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int RW  = $clog2(LINES_PER_LEVEL + 1);
    localparam int SW  = LW + RW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                             state;
    logic [ROWS-1:0][COLS-1:0][CW-1:0]  wbuf;
    logic [RBW-1:0]                     r;
    logic [LW-1:0]                      k;
    logic [RW-1:0]                      rem, rem_n;
    logic                               full;
    logic [3:0]                         pts4, level_n;
    logic [SCORE_W:0]                   score_sum;
    logic [16:0]                        lines_sum;
    logic [SW-1:0]                      s;
    int                                 lv;

    always_comb begin
        full = 1'b1;
        for (int c = 0; c < COLS; c++)
            if (wbuf[r][c] == '0) full = 1'b0;
    end

    assign pts4 = k == LW'(0) ? 4'd0 :
                  k == LW'(1) ? 4'd1 :
                  k == LW'(2) ? 4'd3 :
                  k == LW'(3) ? 4'd5 : 4'd8;
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(pts4);
    assign lines_sum = {1'b0, total_lines} + 17'(k);

    // level advances by repeated subtraction from the remainder; k <= ROWS bounds the iterations
    always_comb begin
        s  = SW'(rem) + SW'(k);
        lv = int'(level);
        for (int i = 0; i <= ROWS / LINES_PER_LEVEL; i++)
            if (s >= SW'(LINES_PER_LEVEL)) begin
                s  = s - SW'(LINES_PER_LEVEL);
                lv = lv + 1;
            end
        rem_n   = RW'(s);
        level_n = lv > 15 ? 4'd15 : 4'(lv);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            grid_o        <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
            score         <= '0;
            level         <= '0;
            rem           <= '0;
            wbuf          <= '0;
            r             <= '0;
            k             <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    wbuf  <= grid_i;
                    r     <= RBW'(ROWS - 1);
                    k     <= '0;
                    busy  <= 1'b1;
                    state <= SCAN;
                end
                SCAN: if (full) begin
                    // r stays put so the row that dropped into it is scanned next
                    for (int i = 1; i < ROWS; i++)
                        if (RBW'(i) <= r) wbuf[i] <= wbuf[i-1];
                    wbuf[0] <= '0;
                    k       <= k + 1'b1;
                end else if (r == '0) begin
                    state <= DONE;
                end else begin
                    r <= r - 1'b1;
                end
                DONE: begin
                    grid_o        <= wbuf;
                    lines_cleared <= k;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (clr_score) begin
                score       <= '0;
                total_lines <= '0;
                level       <= '0;
                rem         <= '0;
            end else if (state == DONE) begin
                score       <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                total_lines <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
                level       <= level_n;
                rem         <= rem_n;
            end
        end
    end
endmodule

// File: tb/tb_tetris_line_clear.sv
// tb_tetris_line_clear: directed and random clear passes checked every cycle against a row-filtering model.
module tb_tetris_line_clear;
    localparam int ROWS = 22, COLS = 10, CW = 3, SW = 4, LW = 5;
    typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] grid_t;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, clr_score = 1'b0;
    grid_t         grid_i = '0, grid_o;
    logic          busy, done;
    logic [LW-1:0] lines_cleared;
    logic [15:0]   total_lines;
    logic [SW-1:0] score;
    logic [3:0]    level;
    int            n_vec = 0, n_err = 0;

    grid_t m_grid, m_pend;
    int    m_lines, m_pk, m_cnt, m_total, m_score;
    bit    m_busy, m_done;

    always #5 clk = ~clk;

    tetris_line_clear #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .clr_score(clr_score), .grid_i(grid_i),
        .busy(busy), .done(done), .grid_o(grid_o), .lines_cleared(lines_cleared),
        .total_lines(total_lines), .score(score), .level(level)
    );

    // Reference: drop every full row, stack survivors at the bottom in order
    function automatic void compact(input grid_t g, output grid_t o, output int k);
        int w;
        bit f;
        o = '0;
        w = ROWS - 1;
        k = 0;
        for (int rr = ROWS - 1; rr >= 0; rr--) begin
            f = 1'b1;
            for (int c = 0; c < COLS; c++) if (g[rr][c] == '0) f = 1'b0;
            if (f) k++;
            else begin
                o[w] = g[rr];
                w--;
            end
        end
    endfunction

    function automatic int pts(input int k);
        return k == 0 ? 0 : k == 1 ? 1 : k == 2 ? 3 : k == 3 ? 5 : 8;
    endfunction

    function automatic grid_t rand_grid();
        grid_t g;
        for (int rr = 0; rr < ROWS; rr++) begin
            bit f;
            f = $urandom_range(0, 3) == 0;
            for (int c = 0; c < COLS; c++)
                g[rr][c] = f ? CW'($urandom_range(1, 7)) : CW'($urandom_range(0, 7));
            if (!f) g[rr][$urandom_range(0, COLS - 1)] = '0;
        end
        return g;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s got %0d want %0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic chkg(input string nm, input grid_t a, input grid_t e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, a, e);
        end
    endtask

    // Timing model: a pass accepted at one edge publishes ROWS+k+1 edges later
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_grid = '0; m_lines = 0; m_cnt = 0; m_total = 0; m_score = 0;
            m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    compact(grid_i, m_pend, m_pk);
                    m_cnt  = ROWS + m_pk + 1;
                    m_busy = 1'b1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_grid  = m_pend;
                    m_lines = m_pk;
                    m_done  = 1'b1;
                    m_busy  = 1'b0;
                    if (!clr_score) begin
                        m_score = m_score + pts(m_pk) > 15 ? 15 : m_score + pts(m_pk);
                        m_total = m_total + m_pk;
                    end
                end
            end
            if (clr_score) begin
                m_score = 0;
                m_total = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("lines_cleared", lines_cleared, m_lines);
            chk("score", score, m_score);
            chk("total_lines", total_lines, m_total > 65535 ? 65535 : m_total);
            chk("level", level, m_total / 10 > 15 ? 15 : m_total / 10);
            chkg("grid_o", grid_o, m_grid);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        clr_score = 1'b0;
    endtask

    task automatic run_pass(input grid_t g, output int lat);
        grid_i = g;
        start  = 1'b1;
        lat    = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pass_timeout got no done want done within 200 cycles");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        grid_t g, ge;
        int    lat, dn;
        do_reset();

        run_pass('0, lat);
        chk("lat_empty", lat, 23);
        chk("lines_empty", lines_cleared, 0);
        chk("score_empty", score, 0);
        chkg("grid_empty", grid_o, '0);

        g = '0;
        for (int c = 0; c < COLS; c++) g[21][c] = 3'b100;
        g[20][0] = 3'b010;
        ge = '0;
        ge[21][0] = 3'b010;
        run_pass(g, lat);
        chk("lat_one", lat, 24);
        chk("lines_one", lines_cleared, 1);
        chk("score_one", score, 1);
        chkg("grid_one", grid_o, ge);

        do_reset();
        g = '0;
        for (int rr = 18; rr < ROWS; rr++)
            for (int c = 0; c < COLS; c++) g[rr][c] = CW'((rr + c) % 7 + 1);
        for (int c = 0; c < 5; c++) g[17][c] = 3'b001;
        ge = '0;
        for (int c = 0; c < 5; c++) ge[21][c] = 3'b001;
        run_pass(g, lat);
        chk("lat_four", lat, 27);
        chk("lines_four", lines_cleared, 4);
        chk("score_four_a", score, 8);
        chkg("grid_four", grid_o, ge);
        run_pass(g, lat);
        chk("score_four_b", score, 15);
        run_pass(g, lat);
        chk("score_four_c", score, 15);
        chk("total_twelve", total_lines, 12);
        chk("level_twelve", level, 1);

        do_reset();
        g = '0;
        for (int c = 0; c < COLS; c++) g[21][c] = 3'b111;
        for (int i = 1; i <= 10; i++) begin
            run_pass(g, lat);
            if (i == 9) chk("level_nine", level, 0);
        end
        chk("total_ten", total_lines, 10);
        chk("level_ten", level, 1);

        grid_i = '0;
        start  = 1'b1;
        dn     = 0;
        for (int n = 0; n < 22; n++) begin
            @(negedge clk);
            if (done) dn++;
        end
        start = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("held_start_dones", dn, 1);

        g = '0;
        for (int c = 0; c < COLS; c++) g[21][c] = 3'b101;
        g[20][0] = 3'b110;
        grid_i = g;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (23) @(negedge clk);
        clr_score = 1'b1;
        @(negedge clk);
        clr_score = 1'b0;
        chk("clr_done", done, 1);
        chk("clr_score", score, 0);
        chk("clr_total", total_lines, 0);
        chk("clr_grid_cell", grid_o[21][0], 3'b110);

        grid_i = rand_grid();
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chkg("arst_grid", grid_o, '0);
        chk("arst_lines", lines_cleared, 0);
        chk("arst_score", score, 0);
        chk("arst_level", level, 0);
        @(negedge clk);
        rst = 1'b0;
        dn  = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("arst_no_done", dn, 0);

        for (int n = 0; n < 4000; n++) begin
            grid_i    = rand_grid();
            start     = $urandom_range(0, 5) == 0;
            clr_score = $urandom_range(0, 80) == 0;
            @(negedge clk);
        end
        start     = 1'b0;
        clr_score = 1'b0;
        repeat (60) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
